axi_channel_perf_monitor: RTL and testbench

Parametrised, synthesizable successor to the testbench AXI transfer/stall logger. It observes NUM_CH generic VALID/READY channels, such as the AW/W/AR/R/B channels of the AXI4 slave under test. For each channel it keeps windowed transfer, burst and stall statistics and checks the handshake protocol: VALID/payload stability and stall timeout. It sits beside the DUT in the top testbench, or in a debug wrapper, and is read through a snapshot/select port instead of log text.

---
 rtl/axi_monitor_pkg.sv | 27 ++
 rtl/axi_hs_channel_mon.sv | 109 ++++++++++
 rtl/axi_channel_perf_monitor.sv | 84 ++++++++
 tb/tb_axi_channel_perf_monitor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_monitor_pkg.sv
// Shared types and helpers for the AXI VALID/READY channel performance monitor.
package axi_monitor_pkg;

    localparam int unsigned DEF_CNT_WIDTH   = 32;
    localparam int unsigned DEF_STALL_LIMIT = 256;
    // Statistics are carried at this fixed width; only the low CNT_WIDTH bits are ever nonzero.
    localparam int unsigned STAT_WIDTH      = 64;

    typedef logic [STAT_WIDTH-1:0] stat_t;

    typedef enum logic {
        CH_IDLE,
        CH_WAIT
    } ch_state_t;

    typedef struct packed {
        stat_t xfer;
        stat_t burst;
        stat_t stall;
        stat_t max_stall;
    } ch_stats_t;

    function automatic stat_t sat_inc(input stat_t value, input stat_t max_value);
        return (value >= max_value) ? max_value : value + stat_t'(1);
    endfunction

endpackage

// File: rtl/axi_hs_channel_mon.sv
// One monitored VALID/READY channel: handshake FSM, payload stability check,
// live statistics, stall run length and stall timeout.
module axi_hs_channel_mon
    import axi_monitor_pkg::*;
#(
    parameter int unsigned PAYLOAD_WIDTH = 64,
    parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int unsigned STALL_LIMIT   = DEF_STALL_LIMIT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     valid,
    input  logic                     ready,
    input  logic                     last,
    input  logic [PAYLOAD_WIDTH-1:0] payload,
    input  logic                     snap,
    input  logic                     err_clear,
    output ch_stats_t                stats,
    output logic                     err_stable,
    output logic                     err_timeout,
    output logic                     err_stable_nxt,
    output logic                     err_timeout_nxt
);

    localparam stat_t CNT_MAX   = stat_t'({CNT_WIDTH{1'b1}});
    localparam stat_t RUN_LIMIT = stat_t'(STALL_LIMIT - 1);

    ch_state_t                state, state_nxt;
    logic [PAYLOAD_WIDTH-1:0] captured;
    ch_stats_t                live;
    stat_t                    run, run_inc;
    logic                     stall_cyc, xfer_cyc, capture, stable_viol, timeout_hit;

    assign stall_cyc   = valid && !ready;
    assign xfer_cyc    = valid && ready;
    assign run_inc     = sat_inc(run, CNT_MAX);
    assign timeout_hit = stall_cyc && (run == RUN_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CH_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CH_IDLE: if (stall_cyc)         state_nxt = CH_WAIT;
            CH_WAIT: if (!valid || ready)   state_nxt = CH_IDLE;
            default:                        state_nxt = CH_IDLE;
        endcase
    end

    // A transfer in WAIT completes cleanly even if the payload moved on the accepting beat.
    always_comb begin
        capture     = 1'b0;
        stable_viol = 1'b0;
        case (state)
            CH_IDLE: capture = stall_cyc;
            CH_WAIT: begin
                if (!valid) begin
                    stable_viol = 1'b1;
                end else if (!ready && (payload != captured)) begin
                    stable_viol = 1'b1;
                    capture     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // stats reflects this cycle's events; the snapshot takes it before the window restarts.
    always_comb begin
        stats = live;
        if (enable) begin
            if (xfer_cyc) begin
                stats.xfer = sat_inc(live.xfer, CNT_MAX);
                if (last) stats.burst = sat_inc(live.burst, CNT_MAX);
            end
            if (stall_cyc) begin
                stats.stall = sat_inc(live.stall, CNT_MAX);
                if (run_inc > live.max_stall) stats.max_stall = run_inc;
            end
        end
    end

    assign err_stable_nxt  = stable_viol || (err_stable && !err_clear);
    assign err_timeout_nxt = timeout_hit || (err_timeout && !err_clear);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured    <= '0;
            live        <= '0;
            run         <= '0;
            err_stable  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (capture) captured <= payload;
            live        <= snap ? ch_stats_t'('0) : stats;
            run         <= stall_cyc ? run_inc : '0;
            err_stable  <= err_stable_nxt;
            err_timeout <= err_timeout_nxt;
        end
    end

endmodule

// File: rtl/axi_channel_perf_monitor.sv
// Multi-channel VALID/READY performance and protocol monitor with a snapshot
// shadow bank read through a channel-select port.
module axi_channel_perf_monitor
    import axi_monitor_pkg::*;
#(
    parameter int unsigned NUM_CH        = 5,
    parameter int unsigned PAYLOAD_WIDTH = 64,
    parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int unsigned STALL_LIMIT   = DEF_STALL_LIMIT,
    localparam int unsigned SEL_WIDTH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [NUM_CH-1:0]               ch_valid,
    input  logic [NUM_CH-1:0]               ch_ready,
    input  logic [NUM_CH-1:0]               ch_last,
    input  logic [NUM_CH*PAYLOAD_WIDTH-1:0] ch_payload,
    input  logic                            snap_req,
    output logic                            snap_valid,
    input  logic [SEL_WIDTH-1:0]            rd_sel,
    output logic [CNT_WIDTH-1:0]            rd_xfer_cnt,
    output logic [CNT_WIDTH-1:0]            rd_burst_cnt,
    output logic [CNT_WIDTH-1:0]            rd_stall_cnt,
    output logic [CNT_WIDTH-1:0]            rd_max_stall,
    input  logic                            err_clear,
    output logic [NUM_CH-1:0]               err_stable,
    output logic [NUM_CH-1:0]               err_timeout,
    output logic                            irq
);

    ch_stats_t         live_stats [NUM_CH];
    ch_stats_t         shadow     [NUM_CH];
    ch_stats_t         sel_stats;
    logic [NUM_CH-1:0] stable_nxt, timeout_nxt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        axi_hs_channel_mon #(
            .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
            .CNT_WIDTH     (CNT_WIDTH),
            .STALL_LIMIT   (STALL_LIMIT)
        ) u_mon (
            .clk             (clk),
            .rst_n           (rst_n),
            .enable          (enable),
            .valid           (ch_valid[i]),
            .ready           (ch_ready[i]),
            .last            (ch_last[i]),
            .payload         (ch_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]),
            .snap            (snap_req),
            .err_clear       (err_clear),
            .stats           (live_stats[i]),
            .err_stable      (err_stable[i]),
            .err_timeout     (err_timeout[i]),
            .err_stable_nxt  (stable_nxt[i]),
            .err_timeout_nxt (timeout_nxt[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) shadow[i] <= '0;
            snap_valid <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (snap_req) begin
                for (int unsigned i = 0; i < NUM_CH; i++) shadow[i] <= live_stats[i];
            end
            snap_valid <= snap_req;
            irq        <= |{stable_nxt, timeout_nxt};
        end
    end

    always_comb begin
        sel_stats = '0;
        if (32'(rd_sel) < NUM_CH) sel_stats = shadow[rd_sel];
    end

    assign rd_xfer_cnt  = CNT_WIDTH'(sel_stats.xfer);
    assign rd_burst_cnt = CNT_WIDTH'(sel_stats.burst);
    assign rd_stall_cnt = CNT_WIDTH'(sel_stats.stall);
    assign rd_max_stall = CNT_WIDTH'(sel_stats.max_stall);

endmodule

// File: tb/tb_axi_channel_perf_monitor.sv
// Directed self-checking bench for axi_channel_perf_monitor (5 channels,
// 4-bit counters, stall limit 4 so saturation and timeout are reachable).
module tb_axi_channel_perf_monitor;

    localparam int unsigned NCH = 5;
    localparam int unsigned PW  = 16;
    localparam int unsigned CW  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [NCH-1:0]    ch_valid, ch_ready, ch_last;
    logic [NCH*PW-1:0] ch_payload;
    logic              snap_req, snap_valid;
    logic [2:0]        rd_sel;
    logic [CW-1:0]     rd_xfer_cnt, rd_burst_cnt, rd_stall_cnt, rd_max_stall;
    logic              err_clear;
    logic [NCH-1:0]    err_stable, err_timeout;
    logic              irq;

    int total = 0;
    int bad   = 0;

    axi_channel_perf_monitor #(
        .NUM_CH        (NCH),
        .PAYLOAD_WIDTH (PW),
        .CNT_WIDTH     (CW),
        .STALL_LIMIT   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .ch_valid     (ch_valid),
        .ch_ready     (ch_ready),
        .ch_last      (ch_last),
        .ch_payload   (ch_payload),
        .snap_req     (snap_req),
        .snap_valid   (snap_valid),
        .rd_sel       (rd_sel),
        .rd_xfer_cnt  (rd_xfer_cnt),
        .rd_burst_cnt (rd_burst_cnt),
        .rd_stall_cnt (rd_stall_cnt),
        .rd_max_stall (rd_max_stall),
        .err_clear    (err_clear),
        .err_stable   (err_stable),
        .err_timeout  (err_timeout),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] sel,
                            input int xfer, input int burst, input int stall, input int mx);
        rd_sel = sel;
        #1;
        check({tag, ".xfer"},  32'(rd_xfer_cnt),  32'(xfer));
        check({tag, ".burst"}, 32'(rd_burst_cnt), 32'(burst));
        check({tag, ".stall"}, 32'(rd_stall_cnt), 32'(stall));
        check({tag, ".max"},   32'(rd_max_stall), 32'(mx));
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; ch_valid = '0; ch_ready = '0; ch_last = '0;
        ch_payload = '0; snap_req = 1'b0; rd_sel = '0; err_clear = 1'b0;
        #12;
        check("rst.snap_valid", 32'(snap_valid), 0);
        check("rst.err_stable", 32'(err_stable), 0);
        check("rst.err_timeout", 32'(err_timeout), 0);
        check("rst.irq", 32'(irq), 0);
        rd_check("rst", 3'd1, 0, 0, 0, 0);
        rst_n = 1'b1; enable = 1'b1;
        step();

        // Clean 4-beat burst on ch1
        for (int b = 0; b < 4; b++) begin
            ch_valid[1] = 1'b1; ch_ready[1] = 1'b1; ch_last[1] = (b == 3);
            ch_payload[1*PW +: PW] = 16'(16'hA000 + b);
            step();
        end
        ch_valid[1] = 1'b0; ch_ready[1] = 1'b0; ch_last[1] = 1'b0;
        snap();
        check("burst.snap_valid", 32'(snap_valid), 1);
        rd_check("burst", 3'd1, 4, 1, 0, 0);
        step();
        check("burst.snap_once", 32'(snap_valid), 0);

        // ch0 stalled 3 cycles then accepted
        ch_valid[0] = 1'b1; ch_ready[0] = 1'b0; ch_payload[0 +: PW] = 16'h1234;
        step(3);
        ch_ready[0] = 1'b1; ch_last[0] = 1'b1;
        step();
        ch_valid[0] = 1'b0; ch_ready[0] = 1'b0; ch_last[0] = 1'b0;
        snap();
        rd_check("stall", 3'd0, 1, 1, 3, 3);
        rd_check("stall.ch1_restart", 3'd1, 0, 0, 0, 0);
        check("stall.err_stable", 32'(err_stable), 0);

        // ch2 drops VALID after two stall cycles
        ch_valid[2] = 1'b1; ch_payload[2*PW +: PW] = 16'h5555;
        step(2);
        check("viol.before", 32'(err_stable), 0);
        ch_valid[2] = 1'b0;
        step();
        check("viol.err_stable", 32'(err_stable), 32'h04);
        check("viol.irq", 32'(irq), 1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("viol.cleared", 32'(err_stable), 0);
        check("viol.irq_cleared", 32'(irq), 0);

        // ch3 stalled 10 cycles with limit 4
        ch_valid[3] = 1'b1; ch_payload[3*PW +: PW] = 16'h0F0F;
        step(3);
        check("tmo.before", 32'(err_timeout), 0);
        step();
        check("tmo.set", 32'(err_timeout), 32'h08);
        check("tmo.irq", 32'(irq), 1);
        step(6);
        ch_ready[3] = 1'b1; ch_last[3] = 1'b1;
        step();
        ch_valid[3] = 1'b0; ch_ready[3] = 1'b0; ch_last[3] = 1'b0;
        check("tmo.sticky", 32'(err_timeout), 32'h08);
        snap();
        rd_check("tmo", 3'd3, 1, 1, 10, 10);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("tmo.cleared", 32'(err_timeout), 0);

        // 20 transfers on ch4 saturate the 4-bit counters
        ch_valid[4] = 1'b1; ch_ready[4] = 1'b1; ch_last[4] = 1'b1;
        step(20);
        ch_valid[4] = 1'b0; ch_ready[4] = 1'b0; ch_last[4] = 1'b0;
        snap();
        rd_check("sat", 3'd4, 15, 15, 0, 0);
        rd_check("sel_oob", 3'd5, 0, 0, 0, 0);

        // Counting disabled: transfer not counted
        enable = 1'b0;
        ch_valid[0] = 1'b1; ch_ready[0] = 1'b1; ch_last[0] = 1'b1;
        step();
        ch_valid[0] = 1'b0; ch_ready[0] = 1'b0; ch_last[0] = 1'b0;
        enable = 1'b1;
        snap();
        rd_check("disabled", 3'd0, 0, 0, 0, 0);

        // Snapshot coincident with a transfer, then a back-to-back snapshot
        ch_valid[1] = 1'b1; ch_ready[1] = 1'b1; ch_last[1] = 1'b1; snap_req = 1'b1;
        step();
        ch_valid[1] = 1'b0; ch_ready[1] = 1'b0; ch_last[1] = 1'b0;
        check("coinc.snap_valid", 32'(snap_valid), 1);
        rd_check("coinc", 3'd1, 1, 1, 0, 0);
        step();
        snap_req = 1'b0;
        check("b2b.snap_valid", 32'(snap_valid), 1);
        rd_check("b2b", 3'd1, 0, 0, 0, 0);

        // New payload change on ch4 in the same cycle as err_clear
        ch_valid[4] = 1'b1; ch_payload[4*PW +: PW] = 16'h1111;
        step();
        ch_payload[4*PW +: PW] = 16'h2222; err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("simul.err_stable", 32'(err_stable), 32'h10);
        check("simul.irq", 32'(irq), 1);
        ch_ready[4] = 1'b1;
        step();
        ch_valid[4] = 1'b0; ch_ready[4] = 1'b0;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;

        // Reset pulsed mid-stall on ch3
        ch_valid[3] = 1'b1; ch_ready[3] = 1'b0;
        step(2);
        snap();
        rd_check("prerst", 3'd3, 0, 0, 3, 3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.snap_valid", 32'(snap_valid), 0);
        check("midrst.err_stable", 32'(err_stable), 0);
        check("midrst.err_timeout", 32'(err_timeout), 0);
        check("midrst.irq", 32'(irq), 0);
        rd_check("midrst", 3'd3, 0, 0, 0, 0);
        ch_valid[3] = 1'b0;
        step();
        rst_n = 1'b1;
        step(3);
        check("postrst.err_stable", 32'(err_stable), 0);
        check("postrst.err_timeout", 32'(err_timeout), 0);
        check("postrst.irq", 32'(irq), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
